dma_copy: RTL and testbench

- Word-granular block-copy engine and bus initiator on the data-RAM port.
- Drives the same ce/we/addr/sel/data signal set as the CPU's memory stage, and copies `len` words from `src_addr` to `dst_addr`.
- Sits beside mips in the SOPC. The top-level mux grants it the data_ram port while busy=1.
- Gives firmware a memcpy without tying up the pipeline.

---
 rtl/dma_copy_pkg.sv | 28 ++
 rtl/dma_copy.sv | 156 +++++++++++++++
 tb/tb_dma_copy.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_copy_pkg.sv
// Shared definitions for the dma_copy block-copy engine: state encodings,
// bus width constants and small helpers used by the datapath.
package dma_copy_pkg;

    // Data and address widths of the data-RAM bus.
    localparam int RegBusW      = 32;
    localparam int InstAddrBusW = 32;

    // FSM encodings.
    typedef enum logic [1:0] {
        DMA_IDLE = 2'd0,
        DMA_RD   = 2'd1,
        DMA_WR   = 2'd2,
        DMA_DONE = 2'd3
    } dma_state_e;

    // Every bus cycle moves a full 32-bit word.
    localparam logic [3:0] WordSel = 4'b1111;

    // Byte distance between consecutive words.
    localparam int WordStride = 4;

    // A byte address is word aligned when its two LSBs are zero.
    function automatic logic is_word_aligned(input logic [1:0] lsbs);
        return (lsbs == 2'b00);
    endfunction

endpackage

// File: rtl/dma_copy.sv
// Word-granular block-copy engine. Alternates one read and one write bus
// cycle per word, copying len words from src_addr to dst_addr in ascending
// order. Bus outputs are registered from the next state so each state's
// bus cycle is valid from the start of its clock cycle.
module dma_copy
    import dma_copy_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [LEN_W-1:0]    len,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                mem_ce_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [3:0]          mem_sel_o,
    output logic [RegBusW-1:0]  mem_data_o,
    input  logic [RegBusW-1:0]  mem_data_i
);

    dma_state_e          state_reg, state_next;
    logic [ADDR_W-1:0]   src_reg, src_next;
    logic [ADDR_W-1:0]   dst_reg, dst_next;
    logic [LEN_W-1:0]    cnt_reg, cnt_next;
    logic [RegBusW-1:0]  buf_reg, buf_next;

    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;
    logic                ce_reg, ce_next;
    logic                we_reg, we_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [3:0]          sel_reg, sel_next;
    logic [RegBusW-1:0]  data_reg, data_next;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_next = state_reg;
        src_next   = src_reg;
        dst_next   = dst_reg;
        cnt_next   = cnt_reg;
        buf_next   = buf_reg;
        err_next   = 1'b0;

        case (state_reg)
            DMA_IDLE: begin
                // abort is irrelevant here; start always takes priority.
                if (start) begin
                    if (!is_word_aligned(src_addr[1:0]) || !is_word_aligned(dst_addr[1:0])) begin
                        err_next = 1'b1;
                    end else if (len == '0) begin
                        state_next = DMA_DONE;
                    end else begin
                        src_next   = src_addr;
                        dst_next   = dst_addr;
                        cnt_next   = len;
                        state_next = DMA_RD;
                    end
                end
            end
            DMA_RD: begin
                if (abort) begin
                    state_next = DMA_IDLE;
                end else begin
                    buf_next   = mem_data_i;
                    state_next = DMA_WR;
                end
            end
            DMA_WR: begin
                // The write of this cycle commits at the edge even when aborted.
                src_next = src_reg + ADDR_W'(WordStride);
                dst_next = dst_reg + ADDR_W'(WordStride);
                cnt_next = cnt_reg - LEN_W'(1);
                if (abort) begin
                    state_next = DMA_IDLE;
                end else if (cnt_reg == LEN_W'(1)) begin
                    state_next = DMA_DONE;
                end else begin
                    state_next = DMA_RD;
                end
            end
            DMA_DONE: begin
                state_next = DMA_IDLE;
            end
            default: begin
                state_next = DMA_IDLE;
            end
        endcase

        // Outputs are a function of the state being entered.
        busy_next = (state_next != DMA_IDLE);
        done_next = (state_next == DMA_DONE);
        ce_next   = (state_next == DMA_RD) || (state_next == DMA_WR);
        we_next   = (state_next == DMA_WR);
        sel_next  = ce_next ? WordSel : 4'b0000;
        addr_next = '0;
        data_next = '0;
        if (state_next == DMA_RD) begin
            addr_next = src_next;
        end else if (state_next == DMA_WR) begin
            addr_next = dst_next;
            data_next = buf_next;
        end
    end

    // State, datapath and bus output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= DMA_IDLE;
            src_reg   <= '0;
            dst_reg   <= '0;
            cnt_reg   <= '0;
            buf_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            ce_reg    <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            sel_reg   <= 4'b0000;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            src_reg   <= src_next;
            dst_reg   <= dst_next;
            cnt_reg   <= cnt_next;
            buf_reg   <= buf_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            ce_reg    <= ce_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            sel_reg   <= sel_next;
            data_reg  <= data_next;
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign err        = err_reg;
    assign mem_ce_o   = ce_reg;
    assign mem_we_o   = we_reg;
    assign mem_addr_o = addr_reg;
    assign mem_sel_o  = sel_reg;
    assign mem_data_o = data_reg;

endmodule

// File: tb/tb_dma_copy.sv
// Directed testbench for dma_copy with a 1024-word RAM model on the bus.
module tb_dma_copy;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        err;
    logic        mem_ce_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;

    logic [31:0] ram [0:1023];

    int n_checks = 0;
    int n_pass   = 0;
    int wr_cnt   = 0;
    int ce_cnt   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    logic [31:0] bus_addr [$];
    logic        bus_we   [$];

    dma_copy #(.ADDR_W(32), .LEN_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mem_ce_o   (mem_ce_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_sel_o  (mem_sel_o),
        .mem_data_o (mem_data_o),
        .mem_data_i (mem_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational read port.
    assign mem_data_i = (mem_ce_o && !mem_we_o) ? ram[mem_addr_o[11:2]] : 32'h0;

    // RAM write commit plus bus activity log, sampled at the edge that ends each cycle.
    always @(posedge clk) begin
        if (mem_ce_o) begin
            ce_cnt++;
            bus_addr.push_back(mem_addr_o);
            bus_we.push_back(mem_we_o);
            if (mem_we_o) begin
                ram[mem_addr_o[11:2]] <= mem_data_o;
                wr_cnt++;
            end
        end
        if (done) done_cnt++;
        if (err) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_cnt = 0;
        ce_cnt = 0;
        done_cnt = 0;
        err_cnt = 0;
        bus_addr.delete();
        bus_we.delete();
    endtask

    // Present a start request; returns #1 after the accepting edge.
    task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        src_addr = s;
        dst_addr = d;
        len = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Bounded wait for done; n is the number of edges waited, -1 on timeout.
    task automatic wait_done(input int max_cyc, output int n);
        n = 0;
        while (!done && n < max_cyc) begin
            tick();
            n++;
        end
        if (!done) n = -1;
    endtask

    int n;

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'hDEAD0000 + 32'(i);
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len = '0;
        tick();
        tick();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done_err", {30'b0, done, err}, 32'd0);
        check("rst_ce_we_sel", {26'b0, mem_ce_o, mem_we_o, mem_sel_o}, 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_data", mem_data_o, 32'd0);
        rst = 1'b0;
        tick();

        // Basic copy of 4 words.
        ram[64] = 32'h11111111; ram[65] = 32'h22222222;
        ram[66] = 32'h33333333; ram[67] = 32'h44444444;
        clear_logs();
        start_xfer(32'h100, 32'h200, 16'd4);
        check("basic_busy", {31'b0, busy}, 32'd1);
        wait_done(40, n);
        check("basic_done_latency", n, 32'd8);
        tick();
        check("basic_done_pulse", {30'b0, done, busy}, 32'd0);
        check("basic_w0", ram[128], 32'h11111111);
        check("basic_w1", ram[129], 32'h22222222);
        check("basic_w2", ram[130], 32'h33333333);
        check("basic_w3", ram[131], 32'h44444444);
        check("basic_bus_len", bus_addr.size(), 32'd8);
        for (int i = 0; i < 8 && i < bus_addr.size(); i++) begin
            check($sformatf("basic_bus%0d_we", i), {31'b0, bus_we[i]}, 32'(i % 2));
            check($sformatf("basic_bus%0d_addr", i), bus_addr[i],
                  ((i % 2) ? 32'h200 : 32'h100) + 32'(4 * (i / 2)));
        end
        check("basic_done_cnt", done_cnt, 32'd1);
        $display("xfer basic src=100 dst=200 len=4 latency=%0d writes=%0d", n, wr_cnt);

        // Zero-length request.
        clear_logs();
        start_xfer(32'h100, 32'h200, 16'd0);
        check("len0_done_busy", {30'b0, done, busy}, 32'd3);
        tick();
        check("len0_after", {30'b0, done, busy}, 32'd0);
        tick();
        check("len0_no_ce", ce_cnt, 32'd0);
        check("len0_done_cnt", done_cnt, 32'd1);
        $display("xfer len0 done_cnt=%0d ce_cnt=%0d", done_cnt, ce_cnt);

        // Misaligned source, then misaligned destination.
        for (int k = 0; k < 2; k++) begin
            clear_logs();
            start_xfer(k ? 32'h100 : 32'h102, k ? 32'h201 : 32'h200, 16'd4);
            check($sformatf("misal%0d_err_busy", k), {30'b0, err, busy}, 32'd2);
            tick();
            check($sformatf("misal%0d_err_clear", k), {30'b0, err, busy}, 32'd0);
            tick();
            check($sformatf("misal%0d_no_ce", k), ce_cnt, 32'd0);
            $display("xfer misaligned case=%0d err_cnt=%0d", k, err_cnt);
        end

        // Abort during the third write cycle of an 8-word copy.
        for (int i = 0; i < 8; i++) ram[256 + i] = 32'hA0000000 + 32'(i);
        clear_logs();
        start_xfer(32'h400, 32'h500, 16'd8);
        for (int i = 0; i < 5; i++) tick();
        check("abort_in_wr", {30'b0, mem_ce_o, mem_we_o}, 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", {30'b0, busy, mem_ce_o}, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("abort_writes", wr_cnt, 32'd3);
        check("abort_w2", ram[322], 32'hA0000002);
        check("abort_w3_untouched", ram[323], 32'hDEAD0000 + 32'd323);
        check("abort_no_done", done_cnt, 32'd0);
        $display("xfer abort writes=%0d done_cnt=%0d", wr_cnt, done_cnt);
        clear_logs();
        start_xfer(32'h400, 32'h540, 16'd2);
        wait_done(40, n);
        check("post_abort_latency", n, 32'd4);
        check("post_abort_w1", ram[337], 32'hA0000001);
        tick();
        $display("xfer post_abort latency=%0d writes=%0d", n, wr_cnt);

        // Source wraps from the top of the address space to zero.
        ram[1022] = 32'hCAFE0001; ram[1023] = 32'hCAFE0002; ram[0] = 32'hCAFE0003;
        clear_logs();
        start_xfer(32'hFFFFFFF8, 32'h300, 16'd3);
        wait_done(40, n);
        check("wrap_latency", n, 32'd6);
        check("wrap_rd0", bus_addr[0], 32'hFFFFFFF8);
        check("wrap_rd1", bus_addr[2], 32'hFFFFFFFC);
        check("wrap_rd2", bus_addr[4], 32'h00000000);
        check("wrap_w2", ram[194], 32'hCAFE0003);
        tick();
        $display("xfer wrap src=fffffff8 dst=300 len=3 latency=%0d", n);

        // Reset in the write cycle following the second read.
        clear_logs();
        start_xfer(32'h100, 32'h600, 16'd4);
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_outputs", {26'b0, busy, done, mem_ce_o, mem_we_o, mem_sel_o[1:0]}, 32'd0);
        check("rst_mid_addr_data", mem_addr_o | mem_data_o, 32'd0);
        check("rst_mid_writes", wr_cnt, 32'd2);
        clear_logs();
        for (int i = 0; i < 10; i++) tick();
        check("rst_mid_no_bus", ce_cnt, 32'd0);
        check("rst_mid_no_done", done_cnt, 32'd0);
        check("rst_mid_w2_untouched", ram[386], 32'hDEAD0000 + 32'd386);
        $display("xfer reset_mid ce_after=%0d done_after=%0d", ce_cnt, done_cnt);

        // Start pulsed while busy is ignored.
        clear_logs();
        start_xfer(32'h100, 32'h700, 16'd3);
        src_addr = 32'h102;
        len = 16'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(40, n);
        check("busy_start_latency", n + 1, 32'd6);
        tick();
        check("busy_start_writes", wr_cnt, 32'd3);
        check("busy_start_no_err", err_cnt, 32'd0);
        check("busy_start_w3_untouched", ram[451], 32'hDEAD0000 + 32'd451);
        $display("xfer busy_start writes=%0d err_cnt=%0d", wr_cnt, err_cnt);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
